mips_reg_file: RTL

General-purpose register file for the MIPS datapath: 32 entries of 32 bits, one synchronous write port and two registered read ports (rs, rt), with register 0 hard-wired to zero. It is the read-side counterpart to the datapath's single-word pipeline registers. The decode stage reads operands through it, and writeback updates it. Read data is captured into output registers with a one-cycle latency and a valid flag, so downstream stages see stable operands during stalls.

---
 rtl/mips_rf_pkg.sv | 16 +
 rtl/rf_read_port.sv | 74 +++++++
 rtl/mips_reg_file.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: shared constants and types for the MIPS general-purpose register file.
//   DATA_W   - register width in bits
//   NUM_REGS - number of architectural registers
//   ADDR_W   - register index width (2**ADDR_W == NUM_REGS)
//   ZERO_REG - index of the hard-wired zero register
package mips_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port of the MIPS register file.
// Selects the operand for this port (zero register forced to 0, optional
// write-before-read forwarding) and captures it into the output register
// whenever rd_en is high; holds the value otherwise (stall).
//
// Configuration macro: RF_BYPASS_EN
//   defined   - a same-edge write to the addressed register is forwarded
//   undefined - the port captures the stored (old) value
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   rd_en       - load the output register at this edge
//   addr        - register index read by this port
//   entry_data  - stored value of the register at addr
//   wr_en, wr_addr, wr_data - write port, used only for forwarding
//   data        - registered operand
module rf_read_port
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = mips_rf_pkg::DATA_W,
    parameter int ADDR_W = mips_rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] entry_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] data_reg;

`ifdef RF_BYPASS_EN
    logic bypass_hit;

    // Forward only for a real write to a non-zero register at this port's address.
    assign bypass_hit = wr_en && (wr_addr == addr);

    always_comb begin
        data_next = entry_data;
        if (addr == ADDR_W'(ZERO_REG)) begin
            data_next = '0;
        end else if (bypass_hit) begin
            data_next = wr_data;
        end
    end
`else
    // Without forwarding the write port does not influence this read port.
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        data_next = entry_data;
        if (addr == ADDR_W'(ZERO_REG)) begin
            data_next = '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
        end else if (rd_en) begin
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

endmodule

// File: rtl/mips_reg_file.sv
// mips_reg_file: 32 x 32 general-purpose register file for the MIPS datapath.
// One synchronous write port, two registered read ports (rs, rt) with a
// shared rd_valid flag. Register 0 is never written and always reads 0.
// All outputs come straight from flops; reset clears storage and outputs
// asynchronously.
//
// Configuration macro: RF_BYPASS_EN (same-edge write-to-read forwarding,
// implemented inside rf_read_port).
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   rd_en             - read request, samples rs_addr / rt_addr
//   rs_addr, rt_addr  - source register indices
//   rs_data, rt_data  - registered operands
//   rd_valid          - high for one cycle after each accepted read
//   wr_en, wr_addr, wr_data - write port
module mips_reg_file
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = mips_rf_pkg::DATA_W,
    parameter int NUM_REGS = mips_rf_pkg::NUM_REGS,
    parameter int ADDR_W   = mips_rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int NUM_PORTS = 2;

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic              rd_valid_reg;

    logic [ADDR_W-1:0] port_addr [NUM_PORTS];
    logic [DATA_W-1:0] port_data [NUM_PORTS];

    // Storage. Entry 0 is cleared by reset and never written, so it stays 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ADDR_W'(ZERO_REG))) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
        end
    end

    assign port_addr[0] = rs_addr;
    assign port_addr[1] = rt_addr;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_read_port
            rf_read_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_read_port (
                .clk        (clk),
                .reset      (reset),
                .rd_en      (rd_en),
                .addr       (port_addr[gi]),
                .entry_data (regs_reg[port_addr[gi]]),
                .wr_en      (wr_en),
                .wr_addr    (wr_addr),
                .wr_data    (wr_data),
                .data       (port_data[gi])
            );
        end
    endgenerate

    assign rs_data  = port_data[0];
    assign rt_data  = port_data[1];
    assign rd_valid = rd_valid_reg;

endmodule
